// File: rtl/noc_packet_ejector.sv
// Hermes boundary-port ejector: parses header/size, filters by address and size, and
// replays accepted packets unmodified from a flit FIFO to a credit-based sink.
module noc_packet_ejector #(
  parameter logic [15:0] EJECTOR_ADDRESS  = 16'h0000,
  parameter int          FLIT_SIZE        = 32,
  parameter int          MAX_PAYLOAD_SIZE = 32,
  parameter int          BUFFER_DEPTH     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 noc_rx_i,
  output logic                 noc_credit_o,
  input  logic [FLIT_SIZE-1:0] noc_data_i,
  output logic                 sink_tx_o,
  input  logic                 sink_credit_i,
  output logic [FLIT_SIZE-1:0] sink_data_o,
  output logic [15:0]          pkt_count_o,
  output logic [15:0]          drop_count_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_SIZE,
    ST_PUSH_HDR,
    ST_PUSH_SIZE,
    ST_PAYLOAD,
    ST_DROP
  } state_e;

  localparam int                   PTR_W     = $clog2(BUFFER_DEPTH);
  localparam logic [FLIT_SIZE-1:0] MAX_SIZE  = FLIT_SIZE'(MAX_PAYLOAD_SIZE);
  localparam logic [FLIT_SIZE-1:0] FLIT_ONE  = FLIT_SIZE'(1);
  localparam logic [PTR_W:0]       DEPTH_CNT = (PTR_W + 1)'(BUFFER_DEPTH);

  state_e               state_q, state_d;
  logic [FLIT_SIZE-1:0] hdr_q, hdr_d;
  logic [FLIT_SIZE-1:0] size_q, size_d;
  logic [FLIT_SIZE-1:0] rem_q, rem_d;
  logic                 match_q, match_d;
  logic [15:0]          pkt_count_q, drop_count_q;
  logic                 pkt_inc, drop_inc;

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 fifo_full, fifo_empty;
  logic                 wr_req, wr_en, rd_en;
  logic [FLIT_SIZE-1:0] wr_data;

  logic                 credit;
  logic                 noc_fire;

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);
  assign wr_en      = wr_req && !fifo_full;
  assign rd_en      = !fifo_empty && sink_credit_i;

  // Credit depends only on registered state, so it never loops through noc_rx_i.
  always_comb begin
    credit = 1'b1;
    case (state_q)
      ST_PUSH_HDR, ST_PUSH_SIZE: credit = 1'b0;
      ST_PAYLOAD:                credit = !fifo_full;
      default:                   credit = 1'b1;
    endcase
  end

  assign noc_fire = noc_rx_i && credit;

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    size_d   = size_q;
    rem_d    = rem_q;
    match_d  = match_q;
    wr_req   = 1'b0;
    wr_data  = noc_data_i;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      ST_HEADER: begin
        if (noc_fire) begin
          hdr_d   = noc_data_i;
          match_d = (noc_data_i[15:0] == EJECTOR_ADDRESS);
          state_d = ST_SIZE;
        end
      end
      ST_SIZE: begin
        if (noc_fire) begin
          size_d = noc_data_i;
          if (match_q && (noc_data_i <= MAX_SIZE)) begin
            state_d = ST_PUSH_HDR;
          end else if (noc_data_i == '0) begin
            drop_inc = 1'b1;
            state_d  = ST_HEADER;
          end else begin
            rem_d   = noc_data_i;
            state_d = ST_DROP;
          end
        end
      end
      ST_PUSH_HDR: begin
        wr_req  = 1'b1;
        wr_data = hdr_q;
        if (!fifo_full) begin
          state_d = ST_PUSH_SIZE;
        end
      end
      ST_PUSH_SIZE: begin
        wr_req  = 1'b1;
        wr_data = size_q;
        if (!fifo_full) begin
          if (size_q == '0) begin
            pkt_inc = 1'b1;
            state_d = ST_HEADER;
          end else begin
            rem_d   = size_q;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        // A transfer here implies the FIFO had room, so the write always lands.
        if (noc_fire) begin
          wr_req = 1'b1;
          rem_d  = rem_q - FLIT_ONE;
          if (rem_q == FLIT_ONE) begin
            pkt_inc = 1'b1;
            state_d = ST_HEADER;
          end
        end
      end
      ST_DROP: begin
        if (noc_fire) begin
          rem_d = rem_q - FLIT_ONE;
          if (rem_q == FLIT_ONE) begin
            drop_inc = 1'b1;
            state_d  = ST_HEADER;
          end
        end
      end
      default: state_d = ST_HEADER;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_HEADER;
      hdr_q        <= '0;
      size_q       <= '0;
      rem_q        <= '0;
      match_q      <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      size_q  <= size_d;
      rem_q   <= rem_d;
      match_q <= match_d;
      if (pkt_inc && (pkt_count_q != 16'hFFFF)) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
      if (drop_inc && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign noc_credit_o = credit;
  assign sink_tx_o    = !fifo_empty;
  assign sink_data_o  = mem_q[rd_ptr_q];
  assign pkt_count_o  = pkt_count_q;
  assign drop_count_o = drop_count_q;
  assign busy_o       = (state_q != ST_HEADER) || !fifo_empty;

endmodule

// File: tb/tb_noc_packet_ejector.sv
// Self-checking bench for noc_packet_ejector: directed latency/backpressure/reset sequences,
// a table of packet vectors, and a randomized run against a packet-level reference model.
module tb_noc_packet_ejector;

  localparam int          W     = 32;
  localparam logic [15:0] ADDR  = 16'h0000;
  localparam int          MAXP  = 32;
  localparam int          DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         noc_rx;
  logic         noc_credit;
  logic [W-1:0] noc_data;
  logic         sink_tx;
  logic         sink_credit;
  logic [W-1:0] sink_data;
  logic [15:0]  pkt_count;
  logic [15:0]  drop_count;
  logic         busy;

  always #5 clk = ~clk;

  noc_packet_ejector #(
    .EJECTOR_ADDRESS (ADDR),
    .FLIT_SIZE       (W),
    .MAX_PAYLOAD_SIZE(MAXP),
    .BUFFER_DEPTH    (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .noc_rx_i     (noc_rx),
    .noc_credit_o (noc_credit),
    .noc_data_i   (noc_data),
    .sink_tx_o    (sink_tx),
    .sink_credit_i(sink_credit),
    .sink_data_o  (sink_data),
    .pkt_count_o  (pkt_count),
    .drop_count_o (drop_count),
    .busy_o       (busy)
  );

  int           nvec = 0;
  int           nerr = 0;
  logic [W-1:0] got_q [$];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] pay_q [$];
  int           exp_pkt  = 0;
  int           exp_drop = 0;
  bit           rand_sink = 1'b0;
  bit           hold_pend = 1'b0;
  logic [W-1:0] hold_data;

  typedef struct {
    logic [W-1:0] hdr;
    logic [W-1:0] size;
    bit           rnd_sink;
    int           exp_out;
    int           exp_drop;
  } vec_t;

  vec_t vtab [8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rand_sink) sink_credit = ($urandom_range(0, 3) != 0);
  end

  // Sink monitor: a transfer happens at the next posedge when tx && credit hold mid-cycle.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        nvec++;
        if (!sink_tx || sink_data !== hold_data) begin
          nerr++;
          $display("FAIL sink_hold: got tx=%0b data=0x%0h, expected tx=1 data=0x%0h",
                   sink_tx, sink_data, hold_data);
        end
      end
      hold_pend = sink_tx && !sink_credit;
      hold_data = sink_data;
      if (sink_tx && sink_credit) got_q.push_back(sink_data);
    end
  end

  // Packet-level reference: accept iff address matches and payload fits, else count a drop.
  function automatic void model_packet(input logic [W-1:0] hdr, input logic [W-1:0] size);
    if (hdr[15:0] == ADDR && size <= MAXP) begin
      exp_q.push_back(hdr);
      exp_q.push_back(size);
      foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
      if (exp_pkt < 65535) exp_pkt++;
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endfunction

  task automatic fill_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back($urandom);
  endtask

  task automatic send_flit(input logic [W-1:0] d, output int waited);
    waited   = 0;
    noc_rx   = 1'b1;
    noc_data = d;
    while (!noc_credit && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!noc_credit) begin
      nvec++;
      nerr++;
      $display("FAIL credit_timeout: got credit=0 for %0d cycles, expected credit=1", waited);
    end
    @(negedge clk);
    noc_rx = 1'b0;
  endtask

  task automatic send_packet(input logic [W-1:0] hdr, input logic [W-1:0] size, input bit gaps);
    int w;
    model_packet(hdr, size);
    send_flit(hdr, w);
    send_flit(size, w);
    foreach (pay_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_flit(pay_q[i], w);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sink_tx) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy || sink_tx) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: got busy=%0b tx=%0b, expected both 0", busy, sink_tx);
    end
  endtask

  task automatic compare_stream(input string name);
    chk($sformatf("%s_len", name), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_flit%0d", name, i), got_q[i], exp_q[i]);
    chk($sformatf("%s_pkt", name), pkt_count, exp_pkt);
    chk($sformatf("%s_drop", name), drop_count, exp_drop);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    noc_rx = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w, stalls, p0, d0;
    logic [W-1:0] r, hdr, size;

    vtab[0] = '{32'h0000_0000, 32'd1,  1'b0, 3,  0};
    vtab[1] = '{32'hDEAD_0000, 32'd4,  1'b1, 6,  0};
    vtab[2] = '{32'h0000_0001, 32'd4,  1'b0, 0,  1};
    vtab[3] = '{32'h1234_0000, 32'd32, 1'b1, 34, 0};
    vtab[4] = '{32'h0000_0000, 32'd33, 1'b0, 0,  1};
    vtab[5] = '{32'h0000_0000, 32'd0,  1'b0, 2,  0};
    vtab[6] = '{32'h0000_8000, 32'd0,  1'b0, 0,  1};
    vtab[7] = '{32'hFFFF_0000, 32'd8,  1'b1, 10, 0};

    rst_n       = 1'b0;
    noc_rx      = 1'b0;
    noc_data    = '0;
    sink_credit = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sink_tx", sink_tx, 1'b0);
    chk("rst_pkt", pkt_count, 16'd0);
    chk("rst_drop", drop_count, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_credit", noc_credit, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic forward with header latency
    pay_q = '{32'hA, 32'hB, 32'hC};
    model_packet(32'h0000_0000, 32'd3);
    send_flit(32'h0000_0000, w);
    send_flit(32'd3, w);
    chk("t1_tx_at_t2", sink_tx, 1'b0);
    chk("t1_credit_push", noc_credit, 1'b0);
    @(negedge clk);
    chk("t1_tx_at_t3", sink_tx, 1'b1);
    chk("t1_head", sink_data, 32'h0000_0000);
    foreach (pay_q[i]) send_flit(pay_q[i], w);
    wait_idle();
    chk("t1_pkt_is_1", pkt_count, 16'd1);
    compare_stream("t1");

    // FIFO fills while sink is stalled
    do_reset();
    sink_credit = 1'b0;
    fill_payload(10);
    model_packet(32'h5A5A_0000, 32'd10);
    send_flit(32'h5A5A_0000, w);
    send_flit(32'd10, w);
    for (int i = 0; i < 6; i++) send_flit(pay_q[i], w);
    chk("t2_credit_full", noc_credit, 1'b0);
    chk("t2_head", sink_data, 32'h5A5A_0000);
    repeat (3) @(negedge clk);
    chk("t2_credit_still_full", noc_credit, 1'b0);
    sink_credit = 1'b1;
    for (int i = 6; i < 10; i++) send_flit(pay_q[i], w);
    wait_idle();
    compare_stream("t2");

    // Address mismatch: dropped at full credit
    do_reset();
    fill_payload(2);
    model_packet(32'h0000_0101, 32'd2);
    stalls = 0;
    send_flit(32'h0000_0101, w); stalls += w;
    send_flit(32'd2, w);         stalls += w;
    foreach (pay_q[i]) begin
      send_flit(pay_q[i], w);
      stalls += w;
    end
    chk("t3_stalls", stalls, 0);
    wait_idle();
    chk("t3_drop_is_1", drop_count, 16'd1);
    chk("t3_pkt_is_0", pkt_count, 16'd0);
    compare_stream("t3");

    // Oversize drop followed by a valid packet
    do_reset();
    fill_payload(40);
    send_packet(32'h0000_0000, 32'd40, 1'b0);
    fill_payload(1);
    send_packet(32'h0000_0000, 32'd1, 1'b0);
    wait_idle();
    chk("t4_out_len", got_q.size(), 3);
    chk("t4_drop_is_1", drop_count, 16'd1);
    compare_stream("t4");

    // Zero-size packet turnaround
    do_reset();
    pay_q.delete();
    model_packet(32'h7777_0000, 32'd0);
    send_flit(32'h7777_0000, w);
    send_flit(32'd0, w);
    chk("t5_credit_push_hdr", noc_credit, 1'b0);
    @(negedge clk);
    chk("t5_credit_push_size", noc_credit, 1'b0);
    @(negedge clk);
    chk("t5_credit_header", noc_credit, 1'b1);
    chk("t5_pkt_is_1", pkt_count, 16'd1);
    fill_payload(1);
    send_packet(32'h0000_0000, 32'd1, 1'b0);
    wait_idle();
    compare_stream("t5");

    // Asynchronous reset mid-payload
    do_reset();
    fill_payload(1);
    send_packet(32'h0000_0000, 32'd1, 1'b0);
    pay_q.delete();
    send_packet(32'h0000_0009, 32'd0, 1'b0);
    wait_idle();
    compare_stream("t6_pre");
    sink_credit = 1'b0;
    fill_payload(10);
    send_flit(32'h0000_0000, w);
    send_flit(32'd10, w);
    for (int i = 0; i < 3; i++) send_flit(pay_q[i], w);
    chk("t6_tx_before", sink_tx, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", sink_tx, 1'b0);
    chk("t6_rst_pkt", pkt_count, 16'd0);
    chk("t6_rst_drop", drop_count, 16'd0);
    chk("t6_rst_credit", noc_credit, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    exp_pkt     = 0;
    exp_drop    = 0;
    sink_credit = 1'b1;
    @(negedge clk);
    fill_payload(2);
    send_packet(32'hABCD_0000, 32'd2, 1'b0);
    wait_idle();
    compare_stream("t6_post");

    // Table-driven packet vectors
    do_reset();
    for (int v = 0; v < 8; v++) begin
      p0 = int'(pkt_count);
      d0 = int'(drop_count);
      rand_sink = vtab[v].rnd_sink;
      if (!vtab[v].rnd_sink) sink_credit = 1'b1;
      fill_payload(int'(vtab[v].size));
      send_packet(vtab[v].hdr, vtab[v].size, 1'b1);
      rand_sink   = 1'b0;
      sink_credit = 1'b1;
      wait_idle();
      chk($sformatf("vec%0d_out_len", v), got_q.size(), vtab[v].exp_out);
      chk($sformatf("vec%0d_drop_delta", v), int'(drop_count) - d0, vtab[v].exp_drop);
      chk($sformatf("vec%0d_pkt_delta", v), int'(pkt_count) - p0, (vtab[v].exp_out != 0) ? 1 : 0);
      compare_stream($sformatf("vec%0d", v));
    end

    // Randomized traffic against the reference model
    do_reset();
    rand_sink = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r    = $urandom;
      hdr  = ($urandom_range(0, 3) != 0) ? {r[31:16], 16'h0000} : r;
      size = ($urandom_range(0, 4) == 0) ? W'($urandom_range(33, 45)) : W'($urandom_range(0, 12));
      fill_payload(int'(size));
      send_packet(hdr, size, 1'b1);
    end
    rand_sink   = 1'b0;
    sink_credit = 1'b1;
    wait_idle();
    compare_stream("rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
